// File: rtl/fifo_pkg.sv
// Shared definitions for the single- and dual-clock FIFOs: read-mode
// selector strings and the level/pointer width helper.
package fifo_pkg;

    // Mode strings are padded into a fixed 5-character vector so that
    // "TRUE" and "FALSE" compare at equal width.
    typedef logic [39:0] mode_str_t;

    localparam mode_str_t FT_TRUE  = "TRUE";
    localparam mode_str_t FT_FALSE = "FALSE";

    // Level and pointer width: one extra bit so a full FIFO (DEPTH entries)
    // is distinguishable from an empty one.
    function automatic int unsigned lvl_width(input int unsigned asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_1c.sv
// Single-clock DEPTH x DSIZE storage array. The write port is synchronous.
// The read port is either combinational (show-ahead) or registered.
module fifo_ram_1c
    import fifo_pkg::*;
#(
    parameter int        DSIZE       = 8,
    parameter int        ASIZE       = 8,
    parameter mode_str_t FALLTHROUGH = FT_TRUE
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic             re_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] rdata_q;

    // Synchronous write port; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port: loads only on an accepted read, holds otherwise.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    // Output select: show-ahead reads the head word directly.
    always_comb begin
        rdata_o = rdata_q;
        if (FALLTHROUGH == FT_TRUE) begin
            rdata_o = mem[raddr_i];
        end
    end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with registered fill level, almost-full/almost-empty
// thresholds, show-ahead or registered read, synchronous flush and sticky
// overflow/underflow flags.
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int        DSIZE       = 8,
    parameter int        ASIZE       = 8,
    parameter mode_str_t FALLTHROUGH = FT_TRUE,
    parameter int        AFULL_LVL   = (1 << ASIZE) - 1,
    parameter int        AEMPTY_LVL  = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [DSIZE-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [DSIZE-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             afull_o,
    output logic             aempty_o,
    output logic [ASIZE:0]   level_o,
    output logic             overflow_o,
    output logic             underflow_o,
    input  logic             clr_err_i
);

    localparam int          DEPTH    = 1 << ASIZE;
    localparam int unsigned LW       = lvl_width(ASIZE);
    localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_LVL);
    localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_LVL);

    // Parameter sanity checks, reported at elaboration.
    if (!(AEMPTY_LVL >= 0 && AEMPTY_LVL < AFULL_LVL && AFULL_LVL <= DEPTH)) begin : g_bad_lvl
        $error("sync_fifo_lvl: need 0 <= AEMPTY_LVL < AFULL_LVL <= DEPTH");
    end
    if (FALLTHROUGH != FT_TRUE && FALLTHROUGH != FT_FALSE) begin : g_bad_mode
        $error("sync_fifo_lvl: FALLTHROUGH must be \"TRUE\" or \"FALSE\"");
    end

    logic [LW-1:0] wbin_q, rbin_q, level_q;
    logic [LW-1:0] wbin_nxt, rbin_nxt;
    logic          wr_acc, rd_acc;
    logic          ovf_q, udf_q, rvalid_q;

    // Accept decode; a full FIFO rejects writes even alongside a read.
    always_comb begin
        wr_acc   = wr_en_i && !full_o  && !flush_i;
        rd_acc   = rd_en_i && !empty_o && !flush_i;
        wbin_nxt = wbin_q + LW'(wr_acc);
        rbin_nxt = rbin_q + LW'(rd_acc);
    end

    // Pointers and level; flush overrides any same-cycle access.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wbin_q  <= '0;
            rbin_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wbin_q  <= '0;
            rbin_q  <= '0;
            level_q <= '0;
        end else begin
            wbin_q  <= wbin_nxt;
            rbin_q  <= rbin_nxt;
            level_q <= wbin_nxt - rbin_nxt;
        end
    end

    // Sticky error flags: a same-cycle set beats the clear; flush has no effect.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en_i && full_o) begin
                ovf_q <= 1'b1;
            end else if (clr_err_i) begin
                ovf_q <= 1'b0;
            end
            if (rd_en_i && empty_o) begin
                udf_q <= 1'b1;
            end else if (clr_err_i) begin
                udf_q <= 1'b0;
            end
        end
    end

    // Registered-mode valid strobe: one cycle per accepted read.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
        end
    end

    // Status flags decoded from the registered level only, so they never glitch.
    always_comb begin
        level_o     = level_q;
        full_o      = (level_q == DEPTH_L);
        empty_o     = (level_q == '0);
        afull_o     = (level_q >= AFULL_L);
        aempty_o    = (level_q <= AEMPTY_L);
        overflow_o  = ovf_q;
        underflow_o = udf_q;
        rd_valid_o  = (FALLTHROUGH == FT_TRUE) ? !empty_o : rvalid_q;
    end

    fifo_ram_1c #(
        .DSIZE       (DSIZE),
        .ASIZE       (ASIZE),
        .FALLTHROUGH (FALLTHROUGH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (wr_acc),
        .waddr_i (wbin_q[ASIZE-1:0]),
        .wdata_i (wr_data_i),
        .re_i    (rd_acc),
        .raddr_i (rbin_q[ASIZE-1:0]),
        .rdata_o (rd_data_o)
    );

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl: one show-ahead and one registered-read
// instance driven by the same stimulus, checked against hand-computed vectors.
module tb_sync_fifo_lvl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fl = 1'b0, wr = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [7:0] wd = '0;

    logic [7:0] ft_d, rg_d;
    logic       ft_v, rg_v;
    logic       ft_full, ft_empty, ft_afull, ft_aempty, ft_ovf, ft_udf;
    logic       rg_full, rg_empty, rg_afull, rg_aempty, rg_ovf, rg_udf;
    logic [2:0] ft_lvl, rg_lvl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_lvl #(
        .DSIZE(8), .ASIZE(2), .FALLTHROUGH("TRUE"), .AFULL_LVL(3), .AEMPTY_LVL(1)
    ) u_ft (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl), .wr_en_i(wr), .wr_data_i(wd),
        .rd_en_i(rd), .rd_data_o(ft_d), .rd_valid_o(ft_v), .full_o(ft_full),
        .empty_o(ft_empty), .afull_o(ft_afull), .aempty_o(ft_aempty),
        .level_o(ft_lvl), .overflow_o(ft_ovf), .underflow_o(ft_udf), .clr_err_i(clr)
    );

    sync_fifo_lvl #(
        .DSIZE(8), .ASIZE(2), .FALLTHROUGH("FALSE"), .AFULL_LVL(3), .AEMPTY_LVL(1)
    ) u_rg (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(fl), .wr_en_i(wr), .wr_data_i(wd),
        .rd_en_i(rd), .rd_data_o(rg_d), .rd_valid_o(rg_v), .full_o(rg_full),
        .empty_o(rg_empty), .afull_o(rg_afull), .aempty_o(rg_aempty),
        .level_o(rg_lvl), .overflow_o(rg_ovf), .underflow_o(rg_udf), .clr_err_i(clr)
    );

    typedef struct {
        logic       wr, rd, fl, clr;
        logic [7:0] wd;
        logic [2:0] lvl;
        logic [5:0] flg;     // {full, empty, afull, aempty, ovf, udf}
        logic       ft_chk;
        logic [7:0] ft_d;
        logic       rg_v;
        logic [7:0] rg_d;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic w, input logic r, input logic f, input logic c,
                                input logic [7:0] d, input logic [2:0] l, input logic [5:0] g,
                                input logic fc, input logic [7:0] fd,
                                input logic rv, input logic [7:0] rdv);
        vec_t v;
        v.wr = w; v.rd = r; v.fl = f; v.clr = c; v.wd = d; v.lvl = l; v.flg = g;
        v.ft_chk = fc; v.ft_d = fd; v.rg_v = rv; v.rg_d = rdv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [2:0] l, input logic [5:0] g);
        chk({tag, " ft level"}, 32'(ft_lvl), 32'(l));
        chk({tag, " ft flags"}, 32'({ft_full, ft_empty, ft_afull, ft_aempty, ft_ovf, ft_udf}), 32'(g));
        chk({tag, " rg level"}, 32'(rg_lvl), 32'(l));
        chk({tag, " rg flags"}, 32'({rg_full, rg_empty, rg_afull, rg_aempty, rg_ovf, rg_udf}), 32'(g));
        chk({tag, " ft valid"}, 32'(ft_v), 32'(!g[4]));
    endtask

    task automatic drive(input logic w, input logic r, input logic f, input logic c, input logic [7:0] d);
        wr = w; rd = r; fl = f; clr = c; wd = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; fl = 1'b0; clr = 1'b0;
    endtask

    initial begin
        // Flags order: full empty afull aempty ovf udf
        vt.push_back(mk(1,0,0,0,8'h11, 1, 6'b000100, 1,8'h11, 0,8'h00));
        vt.push_back(mk(1,0,0,0,8'h22, 2, 6'b000000, 1,8'h11, 0,8'h00));
        vt.push_back(mk(1,0,0,0,8'h33, 3, 6'b001000, 1,8'h11, 0,8'h00));
        vt.push_back(mk(1,0,0,0,8'h44, 4, 6'b101000, 1,8'h11, 0,8'h00));
        vt.push_back(mk(1,0,0,0,8'h55, 4, 6'b101010, 1,8'h11, 0,8'h00)); // overflow, contents kept
        vt.push_back(mk(0,1,0,0,8'h00, 3, 6'b001010, 1,8'h22, 1,8'h11));
        vt.push_back(mk(0,1,0,0,8'h00, 2, 6'b000010, 1,8'h33, 1,8'h22));
        vt.push_back(mk(0,1,0,0,8'h00, 1, 6'b000110, 1,8'h44, 1,8'h33));
        vt.push_back(mk(0,1,0,0,8'h00, 0, 6'b010110, 0,8'h00, 1,8'h44));
        vt.push_back(mk(0,1,0,0,8'h00, 0, 6'b010111, 0,8'h00, 0,8'h44)); // underflow
        vt.push_back(mk(0,0,0,1,8'h00, 0, 6'b010100, 0,8'h00, 0,8'h44)); // clear
        vt.push_back(mk(0,1,0,1,8'h00, 0, 6'b010101, 0,8'h00, 0,8'h44)); // set beats clear
        vt.push_back(mk(0,0,0,1,8'h00, 0, 6'b010100, 0,8'h00, 0,8'h44));
        vt.push_back(mk(1,0,0,0,8'hA5, 1, 6'b000100, 1,8'hA5, 0,8'h44)); // show-ahead before rd
        vt.push_back(mk(0,1,0,0,8'h00, 0, 6'b010100, 0,8'h00, 1,8'hA5)); // registered pulse
        vt.push_back(mk(0,1,0,0,8'h00, 0, 6'b010101, 0,8'h00, 0,8'hA5)); // pulse ended, data held
        vt.push_back(mk(1,0,0,0,8'h01, 1, 6'b000101, 1,8'h01, 0,8'hA5));
        vt.push_back(mk(1,0,0,0,8'h02, 2, 6'b000001, 1,8'h01, 0,8'hA5));
        vt.push_back(mk(1,0,0,0,8'h03, 3, 6'b001001, 1,8'h01, 0,8'hA5));
        vt.push_back(mk(1,1,1,0,8'h04, 0, 6'b010101, 0,8'h00, 0,8'hA5)); // flush wins
        vt.push_back(mk(0,0,0,0,8'h00, 0, 6'b010101, 0,8'h00, 0,8'hA5));
        vt.push_back(mk(1,0,0,0,8'h09, 1, 6'b000101, 1,8'h09, 0,8'hA5));
        vt.push_back(mk(0,1,0,0,8'h00, 0, 6'b010101, 0,8'h00, 1,8'h09));
        vt.push_back(mk(0,0,0,1,8'h00, 0, 6'b010100, 0,8'h00, 0,8'h09));

        // Reset state
        #12;
        chk_status("reset", 3'd0, 6'b010100);
        chk("reset rg valid", 32'(rg_v), 32'd0);
        chk("reset rg data", 32'(rg_d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            drive(vt[i].wr, vt[i].rd, vt[i].fl, vt[i].clr, vt[i].wd);
            chk_status(tag, vt[i].lvl, vt[i].flg);
            if (vt[i].ft_chk) chk({tag, " ft data"}, 32'(ft_d), 32'(vt[i].ft_d));
            chk({tag, " rg valid"}, 32'(rg_v), 32'(vt[i].rg_v));
            chk({tag, " rg data"}, 32'(rg_d), 32'(vt[i].rg_d));
        end

        // Steady state at level 2 with simultaneous read and write; pointers wrap.
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h01);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("rw%0d ft head", k), 32'(ft_d), 32'(k));
            drive(1, 1, 0, 0, 8'(k + 2));
            chk($sformatf("rw%0d level", k), 32'(ft_lvl), 32'd2);
            chk($sformatf("rw%0d rg data", k), 32'(rg_d), 32'(k));
            chk($sformatf("rw%0d rg valid", k), 32'(rg_v), 32'd1);
        end
        chk_status("rw end", 3'd2, 6'b000000);

        // Fill to overflow, then assert reset between edges.
        drive(1, 0, 0, 0, 8'hE0);
        drive(1, 0, 0, 0, 8'hE1);
        drive(1, 0, 0, 0, 8'hE2);
        chk_status("pre-reset", 3'd4, 6'b101010);
        #2;
        rst_n = 1'b0;
        #1;
        chk_status("async reset", 3'd0, 6'b010100);
        chk("async reset rg valid", 32'(rg_v), 32'd0);
        chk("async reset rg data", 32'(rg_d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_status("post-reset", 3'd0, 6'b010100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
